display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Parametrised successor to the fixed 4-digit anode selector. It owns its own refresh prescaler and digit
//  index, and drives NUM_DIGITS active-low anodes plus the 4-bit code of the selected digit to the segment
//  decoder. Display value/blank mask are double-buffered and swapped only at frame boundaries (no tearing).
//  Sits between calculator result logic and the 7-seg segment decoder/pins.
// PARAMETERS
//  NUM_DIGITS  4   number of multiplexed digits (2..8)
//  DIV_LOG2    17  prescaler width; per-digit slot = 2**DIV_LOG2 clk_in cycles (min 4)
// PORTS
//  clk_in       in   1              system clock
//  rst_in       in   1              synchronous, active-high reset
//  value_in     in   4*NUM_DIGITS   digit codes; nibble [4*NUM_DIGITS-1 -: 4] = leftmost digit
//  blank_in     in   NUM_DIGITS     1 = digit dark; bit NUM_DIGITS-1 = leftmost
//  value_load   in   1              1-cycle strobe: capture value_in/blank_in into shadow
//  anode        out  NUM_DIGITS     active-low digit enables; MSB = leftmost
//  digit_code   out  4              code of currently scanned digit
//  scan_tick    out  1              1-cycle pulse when digit index advances
//  frame_start  out  1              1-cycle pulse when index wraps to 0 (buffer swap cycle)
//  `ifdef SCAN_DIM_EN: duty_in in 4 brightness, 0 = 1/16 on, 15 = full on
// BEHAVIOUR
//  Clock and reset: one clock, clk_in. rst_in is synchronous and active-high.
//  Reset: prescaler=0, idx=0, shadow/active value=0, shadow/active blank=all 1s, anode=all 1s,
//   digit_code=0, scan_tick=0, frame_start=0. rst_in mid-frame aborts the scan. Shadow contents are lost.
//  Prescaler: free-running DIV_LOG2-bit up-counter, wraps 2**DIV_LOG2-1 -> 0.
//  Terminal count (prescaler all 1s): next cycle idx advances. idx NUM_DIGITS-1 wraps to 0.
//   scan_tick is registered and asserts in the same cycle the new idx is visible.
//   frame_start = scan_tick & (new idx == 0).
//  Buffering: value_load=1 -> shadow <= {value_in, blank_in} next edge.
//   On the terminal-count cycle with idx==NUM_DIGITS-1: active <= shadow.
//   Simultaneous load + swap: active takes the OLD shadow. The new data lands in shadow and shows next frame.
//  Outputs are registered, 1 cycle behind idx/active:
//   digit_code = active_value[4*(NUM_DIGITS-1-idx) +: 4].
//   anode = all 1s except bit (NUM_DIGITS-1-idx) = 0, unless active_blank[NUM_DIGITS-1-idx]=1.
//   A blanked slot keeps its timing and keeps driving digit_code. Only the anode is suppressed.
//  idx 0 -> leftmost anode low (4 digits: 0111,1011,1101,1110).
//  First cycle after rst_in falls: anode = all 1s (active blank reset). Digits light after first swap.
// CONFIGURATION
//  SCAN_DIM_EN defined:
//   Adds duty_in. Anode low only while prescaler[DIV_LOG2-1 -: 4] <= duty_in. Otherwise all 1s.
//   duty_in is sampled every cycle (no buffering).
//  SCAN_DIM_EN undefined: no duty_in port; anode low for the whole slot.
// STRUCTURE
//  display_pkg:
//   DIGIT_W=4.
//   ANODE_OFF function (all-ones of width N).
//   clog2-based IDX_W helper for idx width.
//  Sub-module scan_prescaler: DIV_LOG2 counter, outputs count and terminal pulse. Reused by keypad scan.
//  Top: idx counter, shadow/active registers, output mux/register, optional dim compare.
// TESTING (NUM_DIGITS=4, DIV_LOG2=4 -> 16-cycle slots)
//  1. Reset then idle, no load:
//     anode=1111 for all cycles; scan_tick every 16 cycles; frame_start every 64.
//  2. Load value_in=16'h1234, blank_in=0:
//     after next frame_start, anode/digit_code cycle 0111/1, 1011/2, 1101/3, 1110/4, each held 16 cycles.
//  3. value_load with 16'hABCD on the exact swap cycle while shadow=16'h1234:
//     next frame shows 1234, the following frame shows ABCD.
//  4. blank_in=4'b1000 with 16'h0042:
//     slot 0 anode=1111 (digit_code=0), slots 1-3 normal; frame period is still 64 cycles.
//  5. rst_in asserted for 1 cycle mid-slot 2:
//     next cycle anode=1111, idx=0, prescaler=0, scan_tick low; the earlier load is gone.
//  6. SCAN_DIM_EN, duty_in=3:
//     anode low for 4 of every 16 cycles per slot; duty_in=15 gives low all 16 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan logic.
package display_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    // All anodes dark; result is MAX_DIGITS wide with the low n bits set.
    function automatic logic [MAX_DIGITS-1:0] ANODE_OFF(input int n);
        logic [MAX_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic int IDX_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running power-of-two prescaler; terminal_o is high while the count is all ones.
module scan_prescaler #(
    parameter int DIV_LOG2 = 17
) (
    input  logic                clk_in,
    input  logic                rst_in,
    output logic [DIV_LOG2-1:0] count_o,
    output logic                terminal_o
);

    logic [DIV_LOG2-1:0] count_q;
    logic [DIV_LOG2-1:0] count_d;

    always_comb begin
        count_d = count_q + DIV_LOG2'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign terminal_o = &count_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed digit scanner with frame-synchronous double-buffered value/blank mask.
// Optional brightness control is compiled in with SCAN_DIM_EN.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_LOG2   = 17
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]         blank_in,
    input  logic                          value_load,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [DIGIT_W-1:0]            digit_code,
    output logic                          scan_tick,
    output logic                          frame_start
`ifdef SCAN_DIM_EN
    ,
    input  logic [3:0]                    duty_in
`endif
);

    localparam int IW = IDX_W(NUM_DIGITS);
    localparam logic [MAX_DIGITS-1:0] OFF_FULL = ANODE_OFF(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF  = OFF_FULL[NUM_DIGITS-1:0];
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [DIV_LOG2-1:0] presc_count;
    logic                presc_terminal;

    logic [IW-1:0]                   idx_q, idx_d;
    logic [DIGIT_W*NUM_DIGITS-1:0]   shadow_value_q, shadow_value_d;
    logic [NUM_DIGITS-1:0]           shadow_blank_q, shadow_blank_d;
    logic [DIGIT_W*NUM_DIGITS-1:0]   active_value_q, active_value_d;
    logic [NUM_DIGITS-1:0]           active_blank_q, active_blank_d;
    logic [NUM_DIGITS-1:0]           anode_q, anode_d;
    logic [DIGIT_W-1:0]              code_q, code_d;
    logic                            scan_tick_q, scan_tick_d;
    logic                            frame_start_q, frame_start_d;
    logic [NUM_DIGITS-1:0]           digit_sel;
    logic                            dim_on;

    scan_prescaler #(
        .DIV_LOG2 (DIV_LOG2)
    ) u_prescaler (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .count_o    (presc_count),
        .terminal_o (presc_terminal)
    );

`ifdef SCAN_DIM_EN
    assign dim_on = (presc_count[DIV_LOG2-1 -: 4] <= duty_in);
`else
    logic unused_presc_count;
    assign unused_presc_count = ^presc_count;
    assign dim_on = 1'b1;
`endif

    // Index, buffering and strobes. A load coinciding with the swap lands in
    // shadow only; active takes the previous shadow contents.
    always_comb begin
        idx_d          = idx_q;
        scan_tick_d    = 1'b0;
        frame_start_d  = 1'b0;
        shadow_value_d = shadow_value_q;
        shadow_blank_d = shadow_blank_q;
        active_value_d = active_value_q;
        active_blank_d = active_blank_q;
        if (value_load) begin
            shadow_value_d = value_in;
            shadow_blank_d = blank_in;
        end
        if (presc_terminal) begin
            scan_tick_d = 1'b1;
            if (idx_q == IDX_LAST) begin
                idx_d          = '0;
                frame_start_d  = 1'b1;
                active_value_d = shadow_value_q;
                active_blank_d = shadow_blank_q;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // Bit gi of anode/blank/value belongs to the digit scanned at idx NUM_DIGITS-1-gi.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_sel[gi] = (idx_q == IW'(NUM_DIGITS - 1 - gi));
        assign anode_d[gi]   = ~(digit_sel[gi] & ~active_blank_q[gi] & dim_on);
    end

    always_comb begin
        code_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel[i]) begin
                code_d = active_value_q[DIGIT_W*i +: DIGIT_W];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx_q          <= '0;
            shadow_value_q <= '0;
            shadow_blank_q <= ALL_OFF;
            active_value_q <= '0;
            active_blank_q <= ALL_OFF;
            anode_q        <= ALL_OFF;
            code_q         <= '0;
            scan_tick_q    <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            shadow_value_q <= shadow_value_d;
            shadow_blank_q <= shadow_blank_d;
            active_value_q <= active_value_d;
            active_blank_q <= active_blank_d;
            anode_q        <= anode_d;
            code_q         <= code_d;
            scan_tick_q    <= scan_tick_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign anode       = anode_q;
    assign digit_code  = code_q;
    assign scan_tick   = scan_tick_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with 4 digits and 16-cycle slots.
module tb_display_scan_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] value_in;
    logic [3:0]  blank_in;
    logic        value_load;
    logic [3:0]  anode;
    logic [3:0]  digit_code;
    logic        scan_tick;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_in = ~clk_in;

    display_scan_ctrl #(
        .NUM_DIGITS (4),
        .DIV_LOG2   (4)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .value_in    (value_in),
        .blank_in    (blank_in),
        .value_load  (value_load),
        .anode       (anode),
        .digit_code  (digit_code),
        .scan_tick   (scan_tick),
        .frame_start (frame_start)
    );

    typedef struct {
        int         k;
        logic [3:0] anode;
        logic [3:0] code;
    } check_t;

    typedef struct {
        int          k;
        logic [15:0] value;
        logic [3:0]  blank;
    } load_t;

    // k counts negedges after the reset edge; reset is re-applied at the edge after K_RST.
    localparam int K_RST = 485;
    localparam int K_END = 620;

    check_t checks[$];
    load_t  loads[$];

    task automatic chk(input string name, input int kk, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d got=%h expected=%h", name, kk, got, exp);
        end
    endtask

    initial begin
        int  j;
        logic exp_tick;
        logic exp_fs;

        rst_in     = 1'b1;
        value_in   = '0;
        blank_in   = '0;
        value_load = 1'b0;

        // reset state
        checks.push_back('{0,   4'b1111, 4'h0});
        // first load becomes visible one cycle after the swap edge at k=192
        checks.push_back('{192, 4'b1111, 4'h0});
        checks.push_back('{193, 4'b0111, 4'h1});
        checks.push_back('{208, 4'b0111, 4'h1});
        checks.push_back('{209, 4'b1011, 4'h2});
        checks.push_back('{224, 4'b1011, 4'h2});
        checks.push_back('{225, 4'b1101, 4'h3});
        checks.push_back('{240, 4'b1101, 4'h3});
        checks.push_back('{241, 4'b1110, 4'h4});
        checks.push_back('{256, 4'b1110, 4'h4});
        // load on the swap cycle: old shadow shown first, new one a frame later
        checks.push_back('{257, 4'b0111, 4'h1});
        checks.push_back('{273, 4'b1011, 4'h2});
        checks.push_back('{300, 4'b1101, 4'h3});
        checks.push_back('{320, 4'b1110, 4'h4});
        checks.push_back('{321, 4'b0111, 4'hA});
        checks.push_back('{337, 4'b1011, 4'hB});
        checks.push_back('{353, 4'b1101, 4'hC});
        checks.push_back('{369, 4'b1110, 4'hD});
        checks.push_back('{384, 4'b1110, 4'hD});
        // leftmost digit blanked, code still driven
        checks.push_back('{385, 4'b1111, 4'h0});
        checks.push_back('{400, 4'b1111, 4'h0});
        checks.push_back('{401, 4'b1011, 4'h0});
        checks.push_back('{417, 4'b1101, 4'h4});
        checks.push_back('{433, 4'b1110, 4'h2});
        checks.push_back('{448, 4'b1110, 4'h2});
        checks.push_back('{449, 4'b1111, 4'h0});
        // reset mid slot 2; pending shadow load is discarded
        checks.push_back('{484, 4'b1101, 4'h4});
        checks.push_back('{486, 4'b1111, 4'h0});
        checks.push_back('{551, 4'b1111, 4'h0});
        checks.push_back('{556, 4'b1111, 4'h0});
        checks.push_back('{K_END, 4'b1111, 4'h0});

        loads.push_back('{128, 16'h1234, 4'b0000});
        loads.push_back('{255, 16'hABCD, 4'b0000});
        loads.push_back('{330, 16'h0042, 4'b1000});
        loads.push_back('{460, 16'h9999, 4'b0000});

        repeat (2) @(posedge clk_in);
        @(negedge clk_in);

        for (int k = 0; k <= K_END; k++) begin
            if (k > 0) begin
                @(negedge clk_in);
            end
            j        = (k > K_RST) ? k - (K_RST + 1) : k;
            exp_tick = (j > 0) && (j % 16 == 0);
            exp_fs   = exp_tick && (j % 64 == 0);
            chk("scan_tick", k, 16'(scan_tick), 16'(exp_tick));
            chk("frame_start", k, 16'(frame_start), 16'(exp_fs));
            if (k <= 192) begin
                chk("idle_anode", k, 16'(anode), 16'hF);
            end
            foreach (checks[i]) begin
                if (checks[i].k == k) begin
                    chk("anode", k, 16'(anode), 16'(checks[i].anode));
                    chk("digit_code", k, 16'(digit_code), 16'(checks[i].code));
                    $display("k=%0d anode=%b digit_code=%h tick=%b frame=%b",
                             k, anode, digit_code, scan_tick, frame_start);
                end
            end

            rst_in     = (k == K_RST);
            value_load = 1'b0;
            foreach (loads[i]) begin
                if (loads[i].k == k) begin
                    value_load = 1'b1;
                    value_in   = loads[i].value;
                    blank_in   = loads[i].blank;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
